simon_nibble_host: RTL and testbench

Host-side initiator for the nibble-serial Simon cipher core interface (clock, shift strobe, 4-bit data in, 4-bit data out). It takes a parallel key and block and shifts them into the core one nibble per cycle, MSB first. It then idles the core for the round-computation window, shifts the result back out and reassembles it into a parallel word. It sits between on-chip test/control logic and the cipher core, so the core can be exercised without an external pin-level driver.

---
 rtl/simon_nibble_host.sv | 138 +++++++++++++
 tb/tb_simon_nibble_host.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/simon_nibble_host.sv
// Host-side nibble-serial driver for the Simon core: load key+block, wait, read back the block.
// Latency: o_done is asserted LN+WAIT_CYCLES+RN+1 edges after the accepted start; all outputs registered.
// No backpressure: i_start is honoured only in IDLE, and requests made while busy or in DONE are dropped.
module simon_nibble_host #(
    parameter int KEY_W       = 64,
    parameter int BLK_W       = 32,
    parameter int WAIT_CYCLES = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_key,
    input  logic [BLK_W-1:0] i_block,
    output logic             o_busy,
    output logic             o_done,
    output logic [BLK_W-1:0] o_result,
    output logic             o_shift,
    output logic [3:0]       o_data,
    input  logic [3:0]       i_data
);

    localparam int SR_W    = KEY_W + BLK_W;
    localparam int LN      = SR_W / 4;
    localparam int RN      = BLK_W / 4;
    localparam int CNT_MAX = (LN > WAIT_CYCLES) ? ((LN > RN) ? LN : RN)
                                                : ((WAIT_CYCLES > RN) ? WAIT_CYCLES : RN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LN_LAST = CNT_W'(LN - 1);
    localparam logic [CNT_W-1:0] WT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RN_LAST = CNT_W'(RN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_READ,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SR_W-1:0]  sr, sr_nxt;
    logic [BLK_W-1:0] acc, acc_nxt, result_nxt;
    logic             busy_nxt, done_nxt, shift_nxt;
    logic [3:0]       data_nxt;
    logic             sample;

    // Pins lag the state by one register stage, so the core's nibble for read cycle n
    // is on i_data while the FSM is already one step ahead (READ cnt>=1, or DONE).
    assign sample = ((state == ST_READ) && (cnt != '0)) || (state == ST_DONE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 1'b1;
        sr_nxt     = sr;
        acc_nxt    = acc;
        result_nxt = o_result;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        shift_nxt  = 1'b0;
        data_nxt   = 4'h0;

        if (sample) begin
            acc_nxt = (acc << 4) | BLK_W'(i_data);
        end

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (i_start) begin
                    state_nxt = ST_LOAD;
                    sr_nxt    = {i_key, i_block};
                end
            end
            ST_LOAD: begin
                busy_nxt  = 1'b1;
                shift_nxt = 1'b1;
                data_nxt  = sr[SR_W-1 -: 4];
                sr_nxt    = sr << 4;
                if (cnt == LN_LAST) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                busy_nxt = 1'b1;
                if (cnt == WT_LAST) begin
                    state_nxt = ST_READ;
                    cnt_nxt   = '0;
                end
            end
            ST_READ: begin
                busy_nxt  = 1'b1;
                shift_nxt = 1'b1;
                if (cnt == RN_LAST) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end
            end
            ST_DONE: begin
                done_nxt   = 1'b1;
                result_nxt = acc_nxt;
                state_nxt  = ST_IDLE;
                cnt_nxt    = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sr       <= '0;
            acc      <= '0;
            o_result <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_shift  <= 1'b0;
            o_data   <= 4'h0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sr       <= sr_nxt;
            acc      <= acc_nxt;
            o_result <= result_nxt;
            o_busy   <= busy_nxt;
            o_done   <= done_nxt;
            o_shift  <= shift_nxt;
            o_data   <= data_nxt;
        end
    end

endmodule

// File: tb/tb_simon_nibble_host.sv
// Bench for simon_nibble_host: default-size instance driven with directed and random transactions,
// plus a small 8/8/1 instance with start held high for back-to-back timing.
module tb_simon_nibble_host;

    localparam int K  = 64;
    localparam int B  = 32;
    localparam int WC = 32;
    localparam int LN = (K + B) / 4;
    localparam int RN = B / 4;
    localparam int T  = LN + WC + RN + 1;

    typedef struct packed {
        logic        shift;
        logic [3:0]  data;
        logic        busy;
        logic        done;
        logic [31:0] res;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [K-1:0]  key = '0;
    logic [B-1:0]  blk = '0;
    logic          busy, done, shift;
    logic [B-1:0]  result;
    logic [3:0]    odata;
    logic [3:0]    din = 4'h0;

    logic          s_rst_n = 1'b0;
    logic          s_start = 1'b0;
    logic [7:0]    s_key = '0;
    logic [7:0]    s_blk = '0;
    logic          s_busy, s_done, s_shift;
    logic [7:0]    s_result;
    logic [3:0]    s_odata;
    logic [3:0]    s_din = 4'h0;

    int            total = 0;
    int            bad = 0;
    exp_t          trq[$];
    logic [31:0]   resq[$];
    logic [31:0]   model_res = '0;

    always #5 clk = ~clk;

    simon_nibble_host #(.KEY_W(K), .BLK_W(B), .WAIT_CYCLES(WC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_key(key), .i_block(blk),
        .o_busy(busy), .o_done(done), .o_result(result), .o_shift(shift), .o_data(odata),
        .i_data(din)
    );

    simon_nibble_host #(.KEY_W(8), .BLK_W(8), .WAIT_CYCLES(1)) dut_s (
        .i_clk(clk), .i_rst_n(s_rst_n), .i_start(s_start), .i_key(s_key), .i_block(s_blk),
        .o_busy(s_busy), .o_done(s_done), .o_result(s_result), .o_shift(s_shift), .o_data(s_odata),
        .i_data(s_din)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected pins for cycle c after a start accepted at edge 0.
    function automatic exp_t model_cycle(input int c, input logic [95:0] kb,
                                         input logic [31:0] rsp, input logic [31:0] prev);
        exp_t e;
        e.shift = ((c >= 1) && (c <= LN)) || ((c >= LN + WC + 1) && (c <= T - 1));
        e.data  = 4'h0;
        if ((c >= 1) && (c <= LN)) e.data = kb[4*(LN-c) +: 4];
        e.busy  = (c >= 1) && (c <= T - 1);
        e.done  = (c == T);
        e.res   = (c >= T) ? rsp : prev;
        return e;
    endfunction

    function automatic logic [3:0] sw_nib(input int c);
        return 4'(c * 7 + 3);
    endfunction

    task automatic run_txn(input logic [63:0] k, input logic [31:0] b, input logic [31:0] rsp,
                           input bit glitch, input int rst_at);
        logic [95:0] kb;
        int          last;
        int          j;
        kb = {k, b};
        @(negedge clk);
        start = 1'b1;
        key   = k;
        blk   = b;
        last  = (rst_at >= 0) ? rst_at : T;
        for (int c = 0; c <= last; c++) trq.push_back(model_cycle(c, kb, rsp, model_res));
        if (rst_at >= 0) begin
            repeat (2) trq.push_back('0);
            model_res = '0;
        end else begin
            resq.push_back(rsp);
            model_res = rsp;
        end
        for (int c = 0; c <= T; c++) begin
            @(negedge clk);
            start = glitch && (c == 10);
            if (c == 0) begin
                key = {$urandom, $urandom};
                blk = $urandom;
            end
            if (glitch && (c == 10)) key = ~k;
            j = c - (LN + WC + 1);
            if ((j >= 0) && (j < RN)) din = rsp[4*(RN-1-j) +: 4];
            else din = 4'($urandom_range(0, 15));
            if (rst_at >= 0) begin
                if (c == rst_at) rst_n = 1'b0;
                if (c == rst_at + 2) begin
                    rst_n = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Monitor: compares pins every cycle and pops the result scoreboard on each o_done.
    initial begin
        exp_t        e;
        logic [31:0] last_res;
        last_res = '0;
        forever begin
            @(posedge clk);
            #1;
            if (trq.size() > 0) e = trq.pop_front();
            else begin
                e     = '0;
                e.res = last_res;
            end
            last_res = e.res;
            chk("shift", shift, e.shift);
            chk("data", odata, e.data);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            chk("result_hold", result, e.res);
            if (done) begin
                chk("done_expected", resq.size() > 0, 1);
                if (resq.size() > 0) chk("done_result", result, resq.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] sw_kb;
        int          p;

        start = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);

        run_txn(64'h1918_1110_0908_0100, 32'h6565_6877, 32'hC69B_E9BB, 1'b0, -1);
        run_txn(64'h1918_1110_0908_0100, 32'h6565_6877, 32'hC69B_E9BB, 1'b1, -1);
        run_txn({$urandom, $urandom}, $urandom, $urandom, 1'b0, 40);
        run_txn(64'h1918_1110_0908_0100, 32'h6565_6877, 32'hC69B_E9BB, 1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_txn({$urandom, $urandom}, $urandom, $urandom, 1'($urandom_range(0, 1)), -1);
        end
        repeat (3) @(negedge clk);

        // Small instance: start held high, three back-to-back transactions of period 9.
        sw_kb   = 16'hA53C;
        s_rst_n = 1'b1;
        s_start = 1'b1;
        s_key   = sw_kb[15:8];
        s_blk   = sw_kb[7:0];
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            p = c % 9;
            chk("sw_shift", s_shift, ((p >= 1) && (p <= 4)) || ((p >= 6) && (p <= 7)));
            chk("sw_busy", s_busy, (p >= 1) && (p <= 7));
            chk("sw_done", s_done, p == 8);
            if ((p >= 1) && (p <= 4)) chk("sw_data", s_odata, sw_kb[4*(4-p) +: 4]);
            if (p == 8) chk("sw_result", s_result, {sw_nib(c - 2), sw_nib(c - 1)});
            s_din = sw_nib(c);
        end
        s_start = 1'b0;

        repeat (3) @(negedge clk);
        chk("res_q_drained", resq.size(), 0);
        chk("trace_drained", trq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
